// File: rtl/clock_pkg.sv
// Shared types and constants for the 24 h clock: time-set FSM states, scan digit
// indices, BCD limits and the wrapping BCD increment used by the time editor.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  localparam int DIG_SEC0  = 0;
  localparam int DIG_SEC1  = 1;
  localparam int DIG_MIN0  = 2;
  localparam int DIG_MIN1  = 3;
  localparam int DIG_HOUR0 = 4;
  localparam int DIG_HOUR1 = 5;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // Packed-BCD +1 that wraps to 00 at max; anything non-BCD or >= max also lands on 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v[3:0] > 4'd9 || v >= max) r = 8'h00;
    else if (v[3:0] == 4'd9)       r = {v[7:4] + 4'd1, 4'h0};
    else                           r = v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, registered press
// pulse. The debounced level is exported only when TIME_SET_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_fast_out,
  input  logic rst,
  input  logic btn,
`ifdef TIME_SET_AUTOREPEAT_EN
  output logic level,
`endif
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, lvl, lvl_d;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with the
  // debounced level, so any bounce back to the old level restarts it.
  always_ff @(posedge clk_fast_out or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      lvl_d <= lvl;
      press <= lvl & ~lvl_d;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        lvl <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef TIME_SET_AUTOREPEAT_EN
  assign level = lvl;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time setter: pauses the BCD counters, edits hh:mm, loads it back.
// Define TIME_SET_AUTOREPEAT_EN for hold-to-repeat on the increment button.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV       = 256
`ifdef TIME_SET_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 128,
  parameter int REPEAT_RATE     = 32
`endif
) (
  input  logic       clk_fast_out,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic       run_en,
  output logic       load,
  output logic [3:0] set_h1,
  output logic [3:0] set_h0,
  output logic [3:0] set_m1,
  output logic [3:0] set_m0,
  output logic [5:0] blink_mask
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        state, state_n;
  logic [7:0]    hour, hour_n, minute, minute_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          phase, phase_n;
  logic [5:0]    mask_n;
  logic          mode_press, inc_press, inc_ev;

`ifdef TIME_SET_AUTOREPEAT_EN
  logic mode_lvl, inc_lvl;
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_fast_out (clk_fast_out),
    .rst          (rst),
    .btn          (btn_mode),
`ifdef TIME_SET_AUTOREPEAT_EN
    .level        (mode_lvl),
`endif
    .press        (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk_fast_out (clk_fast_out),
    .rst          (rst),
    .btn          (btn_inc),
`ifdef TIME_SET_AUTOREPEAT_EN
    .level        (inc_lvl),
`endif
    .press        (inc_press)
  );

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed, rpt_tick, editing;

  assign editing  = (state == ST_SET_HOUR) || (state == ST_SET_MIN);
  assign rpt_tick = editing && inc_lvl &&
                    (rpt_armed ? (rpt_cnt == RATE_LAST) : (rpt_cnt == DELAY_LAST));
  assign inc_ev   = inc_press | rpt_tick;

  // Holding mode alongside inc also stops the repeat: the user is moving on.
  always_ff @(posedge clk_fast_out or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (!editing || !inc_lvl || mode_lvl || state_n != state) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_tick) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`else
  assign inc_ev = inc_press;
`endif

  always_comb begin
    state_n     = state;
    hour_n      = hour;
    minute_n    = minute;
    blink_cnt_n = blink_cnt + 1'b1;
    phase_n     = phase;
    mask_n      = '0;
    // A mode press always takes precedence over a coincident increment.
    unique case (state)
      ST_RUN: if (mode_press) begin
        hour_n   = {cur_h1, cur_h0};
        minute_n = {cur_m1, cur_m0};
        state_n  = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (mode_press)  state_n = ST_SET_MIN;
        else if (inc_ev) hour_n  = bcd_inc(hour, HOUR_MAX);
      end
      ST_SET_MIN: begin
        if (mode_press)  state_n  = ST_COMMIT;
        else if (inc_ev) minute_n = bcd_inc(minute, MIN_MAX);
      end
      ST_COMMIT: state_n = ST_RUN;
      default:   state_n = ST_RUN;
    endcase

    // Fresh phase on every state entry so edited digits start out visible.
    if (state_n != state) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n = '0;
      phase_n     = ~phase;
    end

    if (state_n == ST_SET_HOUR) begin
      mask_n[DIG_HOUR1] = phase_n;
      mask_n[DIG_HOUR0] = phase_n;
    end else if (state_n == ST_SET_MIN) begin
      mask_n[DIG_MIN1] = phase_n;
      mask_n[DIG_MIN0] = phase_n;
    end
  end

  always_ff @(posedge clk_fast_out or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      hour       <= '0;
      minute     <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      run_en     <= 1'b1;
      load       <= 1'b0;
      blink_mask <= '0;
    end else begin
      state      <= state_n;
      hour       <= hour_n;
      minute     <= minute_n;
      blink_cnt  <= blink_cnt_n;
      phase      <= phase_n;
      run_en     <= (state_n == ST_RUN);
      load       <= (state_n == ST_COMMIT);
      blink_mask <= mask_n;
    end
  end

  assign set_h1 = hour[7:4];
  assign set_h0 = hour[3:0];
  assign set_m1 = minute[7:4];
  assign set_m0 = minute[3:0];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed sequences, a vector table and
// random button sequences checked against a press-level behavioural model.
module tb_time_set_ctrl;

  localparam int D   = 16;
  localparam int BD  = 256;
  localparam int RD  = 128;
  localparam int RR  = 32;
  localparam int ENTRY_OFS = D + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] cur_h1 = '0, cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
  logic       run_en, load;
  logic [3:0] set_h1, set_h0, set_m1, set_m0;
  logic [5:0] blink_mask;

  time_set_ctrl dut (
    .clk_fast_out (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_h1       (cur_h1),
    .cur_h0       (cur_h0),
    .cur_m1       (cur_m1),
    .cur_m0       (cur_m0),
    .run_en       (run_en),
    .load         (load),
    .set_h1       (set_h1),
    .set_h0       (set_h0),
    .set_m1       (set_m1),
    .set_m0       (set_m0),
    .blink_mask   (blink_mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load monitor: counts strobes, captures the loaded value, checks strobe shape.
  int          load_cnt = 0;
  logic [15:0] last_ld  = '0;
  logic        prev_load = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_load = 1'b0;
    end else begin
      if (load) begin
        load_cnt++;
        last_ld = {set_h1, set_h0, set_m1, set_m0};
        chk("load_width", {31'd0, prev_load}, 32'd0);
        chk("run_en_in_commit", {31'd0, run_en}, 32'd0);
      end
      if (prev_load) chk("run_en_after_commit", {31'd0, run_en}, 32'd1);
      prev_load = load;
    end
  end

  // Behavioural model: state as 0=RUN 1=hours 2=minutes; values as packed BCD.
  int          m_state = 0;
  logic [7:0]  m_h = '0, m_m = '0;
  int          m_loads = 0;
  logic [15:0] m_last = '0;

  function automatic logic [7:0] mdl_inc(input logic [7:0] v, input int lim);
    int t, u, n;
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    if (t > 9 || u > 9) n = 0;
    else begin
      n = t * 10 + u + 1;
      if (n > lim) n = 0;
    end
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic logic [15:0] get_set();
    return {set_h1, set_h0, set_m1, set_m0};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cur(input logic [15:0] v);
    cur_h1 = v[15:12];
    cur_h0 = v[11:8];
    cur_m1 = v[7:4];
    cur_m0 = v[3:0];
  endtask

  task automatic press_btn(input bit inc);
    if (inc) btn_inc = 1'b1; else btn_mode = 1'b1;
    tick(D + 6);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    tick(D + 6);
  endtask

  task automatic m_press(input bit inc);
    bit committed;
    committed = 1'b0;
    if (!inc) begin
      case (m_state)
        0: begin m_h = {cur_h1, cur_h0}; m_m = {cur_m1, cur_m0}; m_state = 1; end
        1: m_state = 2;
        default: begin m_loads++; m_last = {m_h, m_m}; m_state = 0; committed = 1'b1; end
      endcase
    end else if (m_state == 1) m_h = mdl_inc(m_h, 23);
    else if (m_state == 2)     m_m = mdl_inc(m_m, 59);
    press_btn(inc);
    chk("run_en", {31'd0, run_en}, (m_state == 0) ? 32'd1 : 32'd0);
    chk("set_value", {16'd0, get_set()}, {16'd0, m_h, m_m});
    chk("load_count", load_cnt, m_loads);
    if (committed) chk("load_value", {16'd0, last_ld}, {16'd0, m_last});
  endtask

  typedef struct {
    logic [15:0] cur;
    bit          fmin;
    int          n_inc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[8];

  initial begin
    int k, loads_before;
    logic [7:0]  exp_rpt;
    logic [15:0] rc;

    vt[0] = '{16'h2230, 1'b0, 1, 8'h23};
    vt[1] = '{16'h2230, 1'b0, 2, 8'h00};
    vt[2] = '{16'h2F00, 1'b0, 1, 8'h00};
    vt[3] = '{16'h0900, 1'b0, 1, 8'h10};
    vt[4] = '{16'h1234, 1'b0, 0, 8'h12};
    vt[5] = '{16'h1958, 1'b1, 1, 8'h59};
    vt[6] = '{16'h1958, 1'b1, 2, 8'h00};
    vt[7] = '{16'h126A, 1'b1, 1, 8'h00};

    // Reset state
    tick(3);
    chk("rst_run_en", {31'd0, run_en}, 32'd1);
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_blink", {26'd0, blink_mask}, 32'd0);
    chk("rst_set", {16'd0, get_set()}, 32'd0);
    rst = 1'b0;
    tick(3);

    // Bouncing mode button, then stable: one press, fixed latency, capture 13:45
    set_cur(16'h1345);
    for (int i = 0; i < 10; i++) begin
      btn_mode = (i % 2 == 0);
      tick(1);
    end
    btn_mode = 1'b1;
    k = 0;
    for (int i = 1; i <= D + 20; i++) begin
      @(negedge clk);
      k = i;
      if (!run_en) break;
    end
    chk("bounce_latency", k, D + 4);
    chk("capture_1345", {16'd0, get_set()}, 32'h1345);
    chk("blink_hour_s0", {26'd0, blink_mask}, 32'd0);
    tick(BD - 1);
    chk("blink_hour_last_on", {26'd0, blink_mask}, 32'd0);
    btn_mode = 1'b0;
    tick(1);
    chk("blink_hour_off", {26'd0, blink_mask}, 32'b110000);
    tick(BD - 1);
    chk("blink_hour_off_end", {26'd0, blink_mask}, 32'b110000);
    tick(1);
    chk("blink_hour_on_again", {26'd0, blink_mask}, 32'd0);
    m_state = 1; m_h = 8'h13; m_m = 8'h45;
    m_press(1'b1);
    m_press(1'b0);
    tick(BD - 1 - ENTRY_OFS);
    chk("blink_min_last_on", {26'd0, blink_mask}, 32'd0);
    tick(1);
    chk("blink_min_off", {26'd0, blink_mask}, 32'b001100);

    // Reset in the middle of SET_MIN: immediate outputs, edit dropped, no load
    loads_before = load_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_run_en", {31'd0, run_en}, 32'd1);
    chk("midrst_blink", {26'd0, blink_mask}, 32'd0);
    chk("midrst_set", {16'd0, get_set()}, 32'd0);
    tick(2);
    rst = 1'b0;
    m_state = 0; m_h = '0; m_m = '0;
    tick(50);
    chk("midrst_no_load", load_cnt, loads_before);
    chk("midrst_run", {31'd0, run_en}, 32'd1);

    // Full edit 07:30 -> 10:31
    loads_before = load_cnt;
    set_cur(16'h0730);
    m_press(1'b0);
    repeat (3) m_press(1'b1);
    m_press(1'b0);
    m_press(1'b1);
    m_press(1'b0);
    chk("full_load_value", {16'd0, last_ld}, 32'h1031);
    chk("full_load_once", load_cnt - loads_before, 1);

    // Vector table
    foreach (vt[i]) begin
      set_cur(vt[i].cur);
      m_press(1'b0);
      if (vt[i].fmin) m_press(1'b0);
      for (int n = 0; n < vt[i].n_inc; n++) m_press(1'b1);
      chk($sformatf("vec%0d", i), vt[i].fmin ? {24'd0, set_m1, set_m0} : {24'd0, set_h1, set_h0},
          {24'd0, vt[i].exp});
      while (m_state != 0) m_press(1'b0);
    end

    // Long hold on inc in SET_MIN from 00
`ifdef TIME_SET_AUTOREPEAT_EN
    exp_rpt = 8'h03;
`else
    exp_rpt = 8'h01;
`endif
    set_cur(16'h0000);
    m_press(1'b0);
    m_press(1'b0);
    btn_inc = 1'b1;
    tick(RD + 2 * RR - 8);
    btn_inc = 1'b0;
    tick(D + 6);
    chk("hold_inc", {24'd0, set_m1, set_m0}, {24'd0, exp_rpt});
    m_m = exp_rpt;
    m_press(1'b0);

    // Random press sequences against the model
    for (int it = 0; it < 40; it++) begin
      if (m_state == 0) begin
        rc = 16'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          rc[15:12] = 4'($urandom_range(0, 2));
          rc[11:8]  = 4'($urandom_range(0, 9));
          rc[7:4]   = 4'($urandom_range(0, 5));
          rc[3:0]   = 4'($urandom_range(0, 9));
        end
        set_cur(rc);
      end
      m_press($urandom_range(0, 99) >= 35);
    end
    while (m_state != 0) m_press(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
